// File: rtl/alu_uart_interface_if.sv
// Bus bundle between the UART/ALU frame assembler and its surroundings.
// The slave modport is the assembler's view; master is the environment's view.
interface alu_uart_interface_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_valid;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_alu_data_A;
  logic [NB_DATA-1:0] o_alu_data_B;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_overrun;

  modport master (
    output i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
    input  o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data,
    input  o_tx_start, o_busy, o_overrun
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
    output o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data,
    output o_tx_start, o_busy, o_overrun
  );
endinterface

// File: rtl/alu_uart_interface.sv
// Assembles A/B/opcode bytes from UART RX into ALU inputs and sends the result to UART TX.
// Optional inter-byte timeout enabled by defining ALU_UART_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  alu_uart_interface_if.slave   bus
);
  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX} state_t;

  if (NB_OP > NB_DATA || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("alu_uart_interface: illegal parameter combination");
  end

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               tx_start_q, tx_start_d;
  logic               overrun_q, overrun_d;

`ifdef ALU_UART_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      WAIT_A: if (bus.i_rx_valid) begin
        a_d     = bus.i_rx_data;
        state_d = WAIT_B;
      end
      WAIT_B: if (bus.i_rx_valid) begin
        b_d     = bus.i_rx_data;
        state_d = WAIT_OP;
      end
      WAIT_OP: if (bus.i_rx_valid) begin
        op_d    = bus.i_rx_data[NB_OP-1:0];
        state_d = SEND;
      end
      // ALU has had a full cycle with stable inputs; capture and launch TX.
      SEND: begin
        tx_data_d  = bus.i_alu_result;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
        if (bus.i_rx_valid) overrun_d = 1'b1;
      end
      WAIT_TX: begin
        if (bus.i_rx_valid) overrun_d = 1'b1;
        if (bus.i_tx_done)  state_d   = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase

`ifdef ALU_UART_TIMEOUT_EN
    // Counter only advances on idle cycles mid-frame; expiry abandons the frame.
    cnt_d = '0;
    if ((state_q == WAIT_B || state_q == WAIT_OP) && !bus.i_rx_valid) begin
      if (cnt_q == CNT_LAST) state_d = WAIT_A;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
`endif
  end

  assign bus.o_alu_data_A = a_q;
  assign bus.o_alu_data_B = b_q;
  assign bus.o_alu_op     = op_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_busy       = (state_q == SEND) || (state_q == WAIT_TX);
  assign bus.o_overrun    = overrun_q;
endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed plus randomized frames against a transaction-level model of the assembler.
module tb_alu_uart_interface;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic ov_exp = 1'b0;

  alu_uart_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_interface #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: a few MIPS-style functions.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign bus.i_alu_result = alu_fn(bus.o_alu_data_A, bus.o_alu_data_B, bus.o_alu_op);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; leaves on the next falling edge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  // mode 0: clean; 1: stray byte during WAIT_TX; 2: stray byte together with tx_done
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int gap, input int mode);
    logic [5:0] op6;
    logic [7:0] res;
    op6 = op[5:0];
    res = alu_fn(a, b, op6);
    send_byte(a);
    repeat (gap) @(negedge clk);
    send_byte(b);
    send_byte(op);
    check("busy_send", 16'(bus.o_busy), 16'd1);
    check("start_in_send", 16'(bus.o_tx_start), 16'd0);
    @(negedge clk);
    check("tx_start", 16'(bus.o_tx_start), 16'd1);
    check("tx_data", 16'(bus.o_tx_data), 16'(res));
    check("alu_A", 16'(bus.o_alu_data_A), 16'(a));
    check("alu_B", 16'(bus.o_alu_data_B), 16'(b));
    check("alu_op", 16'(bus.o_alu_op), 16'(op6));
    @(negedge clk);
    check("tx_start_pulse", 16'(bus.o_tx_start), 16'd0);
    check("busy_wait_tx", 16'(bus.o_busy), 16'd1);
    if (mode == 1) begin
      send_byte(8'h7F);
      ov_exp = 1'b1;
      check("overrun_set", 16'(bus.o_overrun), 16'd1);
      check("busy_after_drop", 16'(bus.o_busy), 16'd1);
    end
    bus.i_tx_done = 1'b1;
    if (mode == 2) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'h7F;
      ov_exp = 1'b1;
    end
    @(negedge clk);
    bus.i_tx_done  = 1'b0;
    bus.i_rx_valid = 1'b0;
    check("busy_done", 16'(bus.o_busy), 16'd0);
    check("overrun", 16'(bus.o_overrun), 16'(ov_exp));
    check("A_held", 16'(bus.o_alu_data_A), 16'(a));
    check("B_held", 16'(bus.o_alu_data_B), 16'(b));
    check("op_held", 16'(bus.o_alu_op), 16'(op6));
    check("tx_data_held", 16'(bus.o_tx_data), 16'(res));
    $display("frame A=%02h B=%02h op=%02h gap=%0d mode=%0d -> result %02h", a, b, op, gap, mode, res);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_A"},  16'(bus.o_alu_data_A), 16'd0);
    check({tag, "_B"},  16'(bus.o_alu_data_B), 16'd0);
    check({tag, "_op"}, 16'(bus.o_alu_op), 16'd0);
    check({tag, "_tx"}, 16'(bus.o_tx_data), 16'd0);
    check({tag, "_st"}, 16'(bus.o_tx_start), 16'd0);
    check({tag, "_bz"}, 16'(bus.o_busy), 16'd0);
    check({tag, "_ov"}, 16'(bus.o_overrun), 16'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [8];
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    rst_n          = 1'b0;
    bus.i_rx_data  = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_done  = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_frame(8'h05, 8'h03, 8'h20, 0, 0);
    do_frame(8'h09, 8'h04, 8'hE2, 0, 0);
    do_frame(8'h0C, 8'h0A, 8'h24, 1, 1);
    do_frame(8'h30, 8'h0F, 8'h25, 0, 0);

    // Reset in the middle of a frame clears everything without waiting for a clock.
    send_byte(8'hAA);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n  = 1'b1;
    ov_exp = 1'b0;
    @(negedge clk);
    do_frame(8'h21, 8'h12, 8'h26, 0, 0);

    // tx_done outside WAIT_TX must be ignored.
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    check("tx_done_idle_busy", 16'(bus.o_busy), 16'd0);
    do_frame(8'h80, 8'h02, 8'h03, 0, 2);

`ifdef ALU_UART_TIMEOUT_EN
    send_byte(8'h11);
    repeat (20) @(negedge clk);
    check("timeout_A_kept", 16'(bus.o_alu_data_A), 16'h11);
    do_frame(8'h01, 8'h02, 8'h20, 0, 0);
`else
    do_frame(8'h11, 8'h01, 8'h02, 20, 0);
    do_frame(8'h20, 8'h04, 8'h20, 0, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [7:0] a, b, op;
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = {2'($urandom), ops[$urandom_range(0, 7)][5:0]};
      do_frame(a, b, op, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
